// File: rtl/func_unit_arbiter.sv
// Round-robin arbiter that shares one two-stage FuncA pipeline (ret=a+2, b=a+1+d, c=a/1)
// among NumReq valid/ready requesters, returning tagged results over a backpressured channel.
module func_unit_arbiter #(
  parameter int NumReq  = 4,
  parameter int Width   = 8,
  parameter int IdWidth = $clog2(NumReq)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NumReq-1:0]       i_req_valid,
  output logic [NumReq-1:0]       o_req_ready,
  input  logic [NumReq*Width-1:0] i_req_a,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [IdWidth-1:0]      o_rsp_id,
  output logic [Width-1:0]        o_rsp_ret,
  output logic [Width-1:0]        o_rsp_b,
  output logic [Width-1:0]        o_rsp_c,
  output logic                    o_busy
);
  localparam logic [Width-1:0] FuncD = Width'(32'd1);

  logic               s1_valid_r;
  logic [Width-1:0]   s1_a_r;
  logic [IdWidth-1:0] s1_id_r;
  logic               s2_valid_r;
  logic [Width-1:0]   s2_ret_r;
  logic [Width-1:0]   s2_b_r;
  logic [Width-1:0]   s2_c_r;
  logic [IdWidth-1:0] s2_id_r;
  logic [IdWidth-1:0] ptr_r;

  logic               s2_free_s;
  logic               s1_can_load_s;
  logic               grant_found_s;
  logic               handshake_s;
  logic [IdWidth-1:0] grant_idx_s;
  logic [IdWidth:0]   cand_s;
  logic [NumReq-1:0]  req_ready_s;

  function automatic logic [Width-1:0] func_ret(input logic [Width-1:0] a);
    return a + Width'(32'd2);
  endfunction

  function automatic logic [Width-1:0] func_b(input logic [Width-1:0] a);
    return a + Width'(32'd1) + FuncD;
  endfunction

  // Division by one is the identity, so c is the operand itself.
  function automatic logic [Width-1:0] func_c(input logic [Width-1:0] a);
    return a;
  endfunction

  assign s2_free_s     = !s2_valid_r || i_rsp_ready;
  assign s1_can_load_s = !s1_valid_r || s2_free_s;
  assign handshake_s   = i_rst && grant_found_s && s1_can_load_s;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int off = 0; off < NumReq; off++) begin
      cand_s        = {1'b0, ptr_r} + (IdWidth+1)'(off);
      cand_s        = (cand_s >= (IdWidth+1)'(NumReq)) ? cand_s - (IdWidth+1)'(NumReq) : cand_s;
      grant_idx_s   = (!grant_found_s && i_req_valid[cand_s[IdWidth-1:0]]) ?
                      cand_s[IdWidth-1:0] : grant_idx_s;
      grant_found_s = grant_found_s || i_req_valid[cand_s[IdWidth-1:0]];
    end
  end

  // One-hot accept for the selected requester when the operand stage can take it.
  always_comb begin
    req_ready_s = '0;
    if (handshake_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Round-robin pointer and operand stage.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ptr_r      <= '0;
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_id_r    <= '0;
    end else if (handshake_s) begin
      ptr_r      <= (grant_idx_s == IdWidth'(NumReq - 1)) ? '0 : grant_idx_s + IdWidth'(32'd1);
      s1_valid_r <= 1'b1;
      s1_a_r     <= i_req_a[int'(grant_idx_s)*Width +: Width];
      s1_id_r    <= grant_idx_s;
    end else if (s1_valid_r && s2_free_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Result stage; holds everything stable while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s2_valid_r <= 1'b0;
      s2_ret_r   <= '0;
      s2_b_r     <= '0;
      s2_c_r     <= '0;
      s2_id_r    <= '0;
    end else if (s2_free_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_ret_r <= func_ret(s1_a_r);
        s2_b_r   <= func_b(s1_a_r);
        s2_c_r   <= func_c(s1_a_r);
        s2_id_r  <= s1_id_r;
      end
    end
  end

  assign o_req_ready = req_ready_s;
  assign o_rsp_valid = s2_valid_r;
  assign o_rsp_id    = s2_id_r;
  assign o_rsp_ret   = s2_ret_r;
  assign o_rsp_b     = s2_b_r;
  assign o_rsp_c     = s2_c_r;
  assign o_busy      = s1_valid_r || s2_valid_r;
endmodule

// File: doc/func_unit_arbiter.md
Name: func_unit_arbiter

Overview:
- Shares one pipelined function-evaluation unit among NumReq requesters.
- The unit computes the FuncA result set for operand a: ret = a+2, b = a+1+d with d fixed at 1, c = a/1.
- Arbitration is round-robin, with a valid/ready handshake on every requester port and a single tagged response channel with backpressure.
- Sits between client logic and the shared arithmetic, so the arithmetic is instantiated once rather than once per client.

Parameters:
- NumReq, 4, number of requesters; legal range 2..16.
- Width, 8, operand and result width in bits.
- IdWidth, $clog2(NumReq), width of the response requester tag.

Ports:
- i_clk  input  1  clock; all state on the rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_req_valid  input  NumReq  per-requester request valid.
- o_req_ready  output  NumReq  per-requester accept; one-hot or zero.
- i_req_a  input  NumReq*Width  operands; requester k occupies bits [k*Width +: Width].
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response consumer ready.
- o_rsp_id  output  IdWidth  index of the requester that issued this response.
- o_rsp_ret  output  Width  a+2.
- o_rsp_b  output  Width  a+1+1.
- o_rsp_c  output  Width  a/1, i.e. a.
- o_busy  output  1  high while either pipeline stage holds valid data.

Behaviour:
- Reset (i_rst low, asynchronous):
  - Stage valids clear.
  - Round-robin pointer resets to 0.
  - o_rsp_valid = 0, o_rsp_id = 0, o_rsp_ret = 0, o_rsp_b = 0, o_rsp_c = 0, o_busy = 0, o_req_ready = 0.
  - In-flight transactions are discarded with no response.
  - After reset release, the first grant is possible in the first clock cycle.
- Pipeline:
  - S1 is the operand register: a plus id.
  - S2 is the result register and drives the o_rsp_* outputs directly.
  - S2 loads from S1 when S2 is empty or (o_rsp_valid and i_rsp_ready).
  - S1 loads a granted request when S1 is empty or S1 advances in the same cycle.
  - Handshake in cycle t gives o_rsp_valid in cycle t+2 when there is no backpressure.
  - Sustained throughput is 1 transaction per cycle.
- Arbitration:
  - Combinational round-robin over i_req_valid, starting the search at the pointer.
  - o_req_ready[k] is high only for the selected k, and only when S1 can load.
  - With no valid requesters, or S1 unable to load, o_req_ready = 0.
  - On a handshake with requester k, the pointer becomes (k+1) mod NumReq.
  - With no handshake, the pointer holds.
  - o_req_ready does not depend on i_rsp_ready except through the S1/S2 stall chain; that combinational path is allowed.
- Arithmetic:
  - All results are truncated modulo 2^Width.
  - ret = a+2; b = a+2 (computed as a+1+d, d=1); c = a.
  - Overflow wraps: a = 2^Width-1 gives ret = 1, b = 1, c = 2^Width-1.
- Backpressure:
  - While o_rsp_valid=1 and i_rsp_ready=0, S2 holds all outputs stable.
  - S1 fills if empty, then o_req_ready goes to 0.
  - No data is lost or duplicated.
  - Release of i_rsp_ready allows S2 to drain, S1 to advance and a new grant in the same cycle.
- Simultaneous requests: exactly one grant per cycle; the others wait with valid held.
- Requesters hold i_req_valid and operand stable until ready. A withdrawn request is not an error; arbitration simply re-evaluates.
- Ordering: responses leave in grant order.
- o_busy = S1 valid OR S2 valid.

Test Plan:
- Reset mid-stream: with 2 transactions in flight, pulse i_rst low for 1 cycle → all outputs 0 immediately (asynchronous), no stale response after release, and the next grant goes to requester 0.
- Single request: requester 2, a=5, i_rsp_ready=1, handshake at cycle t → at cycle t+2: o_rsp_valid=1, id=2, ret=7, b=7, c=5; o_busy low at t+3.
- Wrap arithmetic: Width=8, a=0xFF and a=0xFE → ret/b of 0x01/0x00, c of 0xFF/0xFE.
- Fairness: all 4 requesters continuously valid with distinct operands, i_rsp_ready=1 → grant order 0,1,2,3,0,1,… and response ids in the same order at 1 per cycle.
- Backpressure: 3 back-to-back requests, then i_rsp_ready=0 for 5 cycles →
  - S2 holds the first result stable.
  - Exactly one more request is accepted into S1.
  - o_req_ready=0 thereafter.
  - After release, all 3 responses appear in order with no drops or duplicates.
- Pointer hold: requester 1 is granted, then no requests for 3 cycles, then requesters 0 and 3 assert together → requester 3 is granted first (pointer=2), then requester 0.
